// File: rtl/adc_dac_init_sequencer_pkg.sv
// Shared definitions for the ADC/DAC init sequencer: FSM states and table entry layout.
package adc_dac_init_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Entry layout is {sel, data}: sel sits at bit CONF_SIZE, data at [CONF_SIZE-1:0].
  localparam int DATA_LSB = 0;

  function automatic int entry_w(input int conf_size);
    return conf_size + 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adc_dac_init_sequencer_table.sv
// Register file holding the converter write table; combinational read, cleared by reset.
module init_table_regfile
  import adc_dac_init_sequencer_pkg::*;
#(
  parameter int WIDTH  = entry_w(21),
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/adc_dac_init_sequencer.sv
// Replays a table of SPI register writes into the ADC/DAC SPI control stage,
// with fixed setup and transfer times since the SPI stage gives no completion feedback.
module adc_dac_init_sequencer
  import adc_dac_init_sequencer_pkg::*;
#(
  parameter int CONF_SIZE    = 21,
  parameter int DEPTH        = 8,
  parameter int ADDR_W       = 3,
  parameter int SETUP_CYCLES = 4,
  parameter int XFER_CYCLES  = 1024,
  parameter bit AUTO_START   = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tbl_wr_en_i,
  input  logic [ADDR_W-1:0]    tbl_wr_addr_i,
  input  logic                 tbl_wr_sel_i,
  input  logic [CONF_SIZE-1:0] tbl_wr_data_i,
  input  logic [ADDR_W:0]      tbl_count_i,
  input  logic                 start_i,
  output logic                 conf_sel_spi,
  output logic                 conf_en_spi,
  output logic [CONF_SIZE-1:0] conf_spi,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [ADDR_W-1:0]    idx_o
);

  localparam int ENTRY_W = entry_w(CONF_SIZE);
  localparam int SEL_BIT = ENTRY_W - 1;
  localparam int CNT_W   = $clog2(max_int(SETUP_CYCLES, XFER_CYCLES));
  localparam logic [CNT_W-1:0]  SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  XFER_LOAD  = CNT_W'(XFER_CYCLES - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT  = (ADDR_W+1)'(DEPTH);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   idx, last_idx, last_idx_nxt;
  logic                auto_pend;
  logic                go, active, tbl_we;
  logic [ADDR_W:0]     count_clamped;
  logic [ENTRY_W-1:0]  rd_entry, hold_entry, out_entry;

  assign tbl_we        = tbl_wr_en_i && (state == ST_IDLE);
  assign count_clamped = (tbl_count_i > DEPTH_CNT) ? DEPTH_CNT : tbl_count_i;
  assign last_idx_nxt  = ADDR_W'(count_clamped - (ADDR_W+1)'(1));

  init_table_regfile #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_table (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .wr_en  (tbl_we),
    .wr_addr(tbl_wr_addr_i),
    .wr_data({tbl_wr_sel_i, tbl_wr_data_i}),
    .rd_addr(idx),
    .rd_data(rd_entry)
  );

  // busy_o stays up through DONE so a zero-length run still shows one busy cycle.
  always_comb begin
    state_nxt   = state;
    go          = 1'b0;
    active      = 1'b0;
    conf_en_spi = 1'b0;
    done_o      = 1'b0;
    busy_o      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy_o = 1'b0;
        go     = start_i || auto_pend;
        if (go) state_nxt = (count_clamped == '0) ? ST_DONE : ST_SETUP;
      end
      ST_SETUP: begin
        active = 1'b1;
        if (cnt == '0) state_nxt = ST_START;
      end
      ST_START: begin
        active      = 1'b1;
        conf_en_spi = 1'b1;
        state_nxt   = ST_WAIT;
      end
      ST_WAIT: begin
        active = 1'b1;
        if (cnt == '0) state_nxt = (idx == last_idx) ? ST_DONE : ST_SETUP;
      end
      ST_DONE: begin
        done_o    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      idx        <= '0;
      last_idx   <= '0;
      auto_pend  <= AUTO_START;
      hold_entry <= '0;
    end else begin
      state <= state_nxt;
      if (active) hold_entry <= rd_entry;
      case (state)
        ST_IDLE: begin
          if (go) begin
            auto_pend <= 1'b0;
            idx       <= '0;
            last_idx  <= last_idx_nxt;
            cnt       <= SETUP_LOAD;
          end
        end
        ST_SETUP: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        ST_START: cnt <= XFER_LOAD;
        ST_WAIT: begin
          if (cnt == '0) begin
            cnt <= SETUP_LOAD;
            if (idx != last_idx) idx <= idx + ADDR_W'(1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // The table cannot change while busy, so reading it live during a run is stable;
  // outside a run the last sent entry is held.
  assign out_entry    = active ? rd_entry : hold_entry;
  assign conf_sel_spi = out_entry[SEL_BIT];
  assign conf_spi     = out_entry[CONF_SIZE-1:DATA_LSB];
  assign idx_o        = idx;

endmodule

// File: tb/tb_adc_dac_init_sequencer.sv
// Self-checking bench for adc_dac_init_sequencer: vector table, randomized runs and corner sequences.
module tb_adc_dac_init_sequencer;

  localparam int CONF_SIZE = 21;
  localparam int DEPTH     = 8;
  localparam int ADDR_W    = 3;
  localparam int SETUP     = 4;
  localparam int XFER      = 32;
  localparam int PER       = SETUP + 1 + XFER;
  localparam int HELD_PER  = SETUP + XFER + 3;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic                 tbl_wr_en_i;
  logic [ADDR_W-1:0]    tbl_wr_addr_i;
  logic                 tbl_wr_sel_i;
  logic [CONF_SIZE-1:0] tbl_wr_data_i;
  logic [ADDR_W:0]      tbl_count_i;
  logic                 start_i;
  logic                 conf_sel_spi;
  logic                 conf_en_spi;
  logic [CONF_SIZE-1:0] conf_spi;
  logic                 busy_o;
  logic                 done_o;
  logic [ADDR_W-1:0]    idx_o;

  adc_dac_init_sequencer #(
    .CONF_SIZE   (CONF_SIZE),
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .SETUP_CYCLES(SETUP),
    .XFER_CYCLES (XFER),
    .AUTO_START  (1'b1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .tbl_wr_en_i  (tbl_wr_en_i),
    .tbl_wr_addr_i(tbl_wr_addr_i),
    .tbl_wr_sel_i (tbl_wr_sel_i),
    .tbl_wr_data_i(tbl_wr_data_i),
    .tbl_count_i  (tbl_count_i),
    .start_i      (start_i),
    .conf_sel_spi (conf_sel_spi),
    .conf_en_spi  (conf_en_spi),
    .conf_spi     (conf_spi),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .idx_o        (idx_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                   cyc;
    bit                   sel;
    logic [CONF_SIZE-1:0] data;
    int                   idx;
  } ev_t;

  typedef struct {
    int cnt;
    int exp_n;
    int exp_done;
  } vec_t;

  ev_t  en_q[$];
  int   done_q[$];
  ev_t  mon_ev;
  logic [CONF_SIZE:0] mtab [DEPTH];
  int   n_checks = 0;
  int   n_errs   = 0;

  // Observed start pulses and done pulses, timestamped by cycle.
  always @(negedge clk) begin
    if (conf_en_spi === 1'b1) begin
      mon_ev.cyc  = cyc;
      mon_ev.sel  = conf_sel_spi;
      mon_ev.data = conf_spi;
      mon_ev.idx  = int'(idx_o);
      en_q.push_back(mon_ev);
    end
    if (done_o === 1'b1) done_q.push_back(cyc);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_pulses(input int cnt);
    return (cnt > DEPTH) ? DEPTH : cnt;
  endfunction

  function automatic int model_done(input int cnt);
    return model_pulses(cnt) * PER + 1;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input int a, input bit s, input logic [CONF_SIZE-1:0] d);
    tbl_wr_en_i   = 1'b1;
    tbl_wr_addr_i = ADDR_W'(a);
    tbl_wr_sel_i  = s;
    tbl_wr_data_i = d;
    step();
    tbl_wr_en_i   = 1'b0;
    mtab[a]       = {s, d};
  endtask

  task automatic launch(input int cnt, output int c0);
    tbl_count_i = (ADDR_W+1)'(cnt);
    start_i     = 1'b1;
    en_q.delete();
    done_q.delete();
    c0 = cyc;
    step();
    start_i = 1'b0;
  endtask

  task automatic check_run(input string tag, input int c0, input int exp_n,
                           input int exp_done, input bit junk);
    while (done_q.size() == 0 && cyc < c0 + exp_done + 20) begin
      step();
      if (junk && cyc < c0 + 20) begin
        start_i       = 1'($urandom_range(0, 1));
        tbl_wr_en_i   = 1'($urandom_range(0, 1));
        tbl_wr_addr_i = ADDR_W'($urandom_range(0, DEPTH - 1));
        tbl_wr_sel_i  = 1'($urandom_range(0, 1));
        tbl_wr_data_i = CONF_SIZE'($urandom);
        tbl_count_i   = (ADDR_W+1)'($urandom_range(0, 15));
      end else begin
        start_i     = 1'b0;
        tbl_wr_en_i = 1'b0;
      end
    end
    chk({tag, "_done_seen"}, longint'(done_q.size() > 0), 1);
    if (done_q.size() > 0) chk({tag, "_done_cyc"}, done_q[0] - c0, exp_done);
    chk({tag, "_pulses"}, en_q.size(), exp_n);
    for (int k = 0; k < en_q.size() && k < exp_n; k++) begin
      chk($sformatf("%s_en%0d_cyc", tag, k), en_q[k].cyc - c0, SETUP + 1 + k * PER);
      chk($sformatf("%s_en%0d_idx", tag, k), en_q[k].idx, k);
      chk($sformatf("%s_en%0d_sel", tag, k), en_q[k].sel, mtab[k][CONF_SIZE]);
      chk($sformatf("%s_en%0d_data", tag, k), en_q[k].data, mtab[k][CONF_SIZE-1:0]);
    end
    step();
    chk({tag, "_idle_busy"}, busy_o, 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_sel"},  conf_sel_spi, 0);
    chk({tag, "_en"},   conf_en_spi, 0);
    chk({tag, "_spi"},  conf_spi, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_idx"},  idx_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs [6];
    int   c0;
    int   cnt;

    vecs[0] = '{0, 0, 1};
    vecs[1] = '{1, 1, 38};
    vecs[2] = '{2, 2, 75};
    vecs[3] = '{8, 8, 297};
    vecs[4] = '{15, 8, 297};
    vecs[5] = '{9, 8, 297};

    rst_i         = 1'b1;
    tbl_wr_en_i   = 1'b0;
    tbl_wr_addr_i = '0;
    tbl_wr_sel_i  = 1'b0;
    tbl_wr_data_i = '0;
    tbl_count_i   = (ADDR_W+1)'(2);
    start_i       = 1'b0;
    for (int i = 0; i < DEPTH; i++) mtab[i] = '0;
    #2 rst_i = 1'b0;
    repeat (3) step();
    chk_zero_outputs("rst");

    // Reset release auto-starts; a write in that same cycle must land before the run reads it.
    rst_i         = 1'b1;
    tbl_count_i   = (ADDR_W+1)'(2);
    tbl_wr_en_i   = 1'b1;
    tbl_wr_addr_i = '0;
    tbl_wr_sel_i  = 1'b1;
    tbl_wr_data_i = 21'h012345;
    mtab[0]       = {1'b1, 21'h012345};
    en_q.delete();
    done_q.delete();
    c0 = cyc;
    check_run("auto", c0, 2, 2 * PER + 1, 1'b0);

    wr(1, 1'b0, 21'h0ABCDE);
    launch(2, c0);
    check_run("plan", c0, 2, 75, 1'b0);

    for (int k = 2; k < DEPTH; k++) wr(k, (k % 2) == 1, CONF_SIZE'(21'h100000 + k * 21'h01111));

    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].cnt, c0);
      check_run($sformatf("vec%0d", i), c0, vecs[i].exp_n, vecs[i].exp_done, 1'b0);
    end

    // Random table updates in IDLE, random counts, and ignored start/write traffic mid-run.
    for (int r = 0; r < 6; r++) begin
      repeat (2) wr(int'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 1)), CONF_SIZE'($urandom));
      cnt = int'($urandom_range(0, 15));
      launch(cnt, c0);
      check_run($sformatf("rnd%0d", r), c0, model_pulses(cnt), model_done(cnt), model_pulses(cnt) > 0);
    end

    // start_i held high: back-to-back runs with one IDLE cycle between them.
    tbl_count_i = (ADDR_W+1)'(1);
    start_i     = 1'b1;
    en_q.delete();
    done_q.delete();
    c0 = cyc;
    while (done_q.size() < 3 && cyc < c0 + 200) step();
    start_i = 1'b0;
    chk("held_dones", done_q.size(), 3);
    for (int k = 0; k < 3 && k < en_q.size() && k < done_q.size(); k++) begin
      chk($sformatf("held_en%0d_cyc", k), en_q[k].cyc - c0, SETUP + 1 + k * HELD_PER);
      chk($sformatf("held_done%0d_cyc", k), done_q[k] - c0, k * HELD_PER + PER + 1);
    end
    repeat (5) step();
    chk("held_pulses", en_q.size(), 3);
    chk("held_idle_busy", busy_o, 0);

    // Asynchronous reset during WAIT of entry 1, then auto-start from a cleared table.
    launch(3, c0);
    while (en_q.size() < 2 && cyc < c0 + 200) step();
    repeat (5) step();
    chk("mid_idx", idx_o, 1);
    chk("mid_busy", busy_o, 1);
    rst_i = 1'b0;
    #1;
    chk_zero_outputs("arst");
    for (int i = 0; i < DEPTH; i++) mtab[i] = '0;
    repeat (2) step();
    rst_i       = 1'b1;
    tbl_count_i = (ADDR_W+1)'(2);
    en_q.delete();
    done_q.delete();
    c0 = cyc;
    check_run("rearm", c0, 2, 75, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
